// File: rtl/leve1_if_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response channel,
// redirect input and the valid/ready channel toward decode.
interface leve1_if_if #(
  parameter int XLEN = 32
);
  logic            IMEM_REQ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_GNT;
  logic            IMEM_RVALID;
  logic [31:0]     IMEM_RDATA;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            OVALID;
  logic            OREADY;
  logic [XLEN-1:0] OPC;
  logic [31:0]     OINSTR;

  // Fetch stage side
  modport master (
    output IMEM_REQ, IMEM_ADDR, OVALID, OPC, OINSTR,
    input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, OREADY
  );

  // Memory / decode / redirect side
  modport slave (
    input  IMEM_REQ, IMEM_ADDR, OVALID, OPC, OINSTR,
    output IMEM_GNT, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, OREADY
  );
endinterface

// File: rtl/leve1_if.sv
// LEVE1 instruction fetch: sequential PC generation, credit-limited memory
// requests, in-order response capture into a small {pc, instr} FIFO, and
// redirect flush that discards buffered and in-flight instructions.
module leve1_if #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 2
) (
  input logic          CLK,
  input logic          RSTn,
  leve1_if_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] pcq [DEPTH];
  logic [AW-1:0]   pq_wp, pq_rp;
  logic [CW-1:0]   outst, cnt, drop;
  logic [XLEN-1:0] f_pc  [DEPTH];
  logic [31:0]     f_ins [DEPTH];
  logic [AW-1:0]   f_wp, f_rp;

  logic            pop, gnt, rsp, push;
  logic [CW:0]     credit;

  // Credit includes the same-cycle pop so a full pipe keeps 1 instr/cycle;
  // this makes OREADY -> IMEM_REQ combinational. Responses with nothing
  // outstanding (e.g. stale ones after reset) are ignored.
  always_comb begin
    pop    = (cnt != '0) && bus.OREADY;
    credit = {1'b0, outst} + {1'b0, cnt} - (CW+1)'(pop);
    gnt    = bus.IMEM_REQ && bus.IMEM_GNT;
    rsp    = bus.IMEM_RVALID && (outst != '0);
    push   = rsp && (drop == '0) && !bus.REDIRECT;
  end

  assign bus.IMEM_REQ  = RSTn && !bus.REDIRECT && (credit < (CW+1)'(DEPTH));
  assign bus.IMEM_ADDR = fpc;
  assign bus.OVALID    = (cnt != '0);
  assign bus.OPC       = f_pc[f_rp];
  assign bus.OINSTR    = f_ins[f_rp];

  // Control state: fetch PC, pending-PC pointers, outstanding/drop/fifo counts
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fpc   <= RESET_PC;
      pq_wp <= '0;
      pq_rp <= '0;
      outst <= '0;
      cnt   <= '0;
      drop  <= '0;
      f_wp  <= '0;
      f_rp  <= '0;
    end else begin
      if (gnt) pq_wp <= pq_wp + 1'b1;
      if (rsp) pq_rp <= pq_rp + 1'b1;
      outst <= outst + CW'(gnt) - CW'(rsp);
      if (bus.REDIRECT) begin
        // No grant can happen this cycle, so everything still outstanding
        // after this cycle's response is stale.
        fpc  <= {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
        drop <= outst - CW'(rsp);
        cnt  <= '0;
        f_wp <= '0;
        f_rp <= '0;
      end else begin
        if (gnt) fpc <= fpc + XLEN'(4);
        if (rsp && (drop != '0)) drop <= drop - 1'b1;
        if (push) f_wp <= f_wp + 1'b1;
        if (pop)  f_rp <= f_rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage: PC of each granted request, then {pc, instr} on accepted response
  always_ff @(posedge CLK) begin
    if (gnt) pcq[pq_wp] <= fpc;
    if (push) begin
      f_pc[f_wp]  <= pcq[pq_rp];
      f_ins[f_wp] <= bus.IMEM_RDATA;
    end
  end

`ifdef DEBUG
  // A response with nothing outstanding is a memory protocol violation.
  a_rvalid_outst: assert property (@(posedge CLK) disable iff (!RSTn)
    bus.IMEM_RVALID |-> (outst != '0));
`endif
endmodule

// File: tb/tb_leve1_if.sv
// Bench for leve1_if: a behavioural memory (queue of granted addresses with
// a due cycle) and a stream model (instructions leave in PC order from the
// last reset/redirect, each carrying the word the memory holds at that PC).
module tb_leve1_if;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk, rstn;
  leve1_if_if #(.XLEN(32)) bus();

  leve1_if #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
    .CLK(clk), .RSTn(rstn), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] a; int due; } pend_t;
  typedef struct {
    logic [31:0] rpc; int lat; int n; logic [31:0] first; logic [31:0] last;
  } rv_t;

  pend_t       pq[$];
  logic [31:0] tx_log[$];
  rv_t         tbl[4];

  int          total = 0, pass = 0, cyc = 0, lat = 1, ntx = 0;
  logic        gnt_val, rdy_val, redir_val;
  logic [31:0] redir_pc;
  logic [31:0] exp_pc, exp_fpc, held_pc, held_ins, last_addr;
  logic        stall_prev, last_req, last_ovalid;

  // Memory contents: a fixed scramble of the word address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock cycle: drive at negedge, sample #1 later, advance past posedge
  task automatic step();
    logic rsp, grant;
    pend_t p;
    bus.REDIRECT    = redir_val;
    bus.REDIRECT_PC = redir_pc;
    bus.OREADY      = rdy_val;
    bus.IMEM_GNT    = gnt_val;
    rsp = (pq.size() > 0) && (pq[0].due <= cyc);
    bus.IMEM_RVALID = rsp;
    if (rsp) bus.IMEM_RDATA = mem(pq[0].a);
    else     bus.IMEM_RDATA = $urandom;
    #1;
    last_req    = bus.IMEM_REQ;
    last_addr   = bus.IMEM_ADDR;
    last_ovalid = bus.OVALID;
    if (redir_val) chk("redirect_req_low", 32'(bus.IMEM_REQ), 32'd0);
    if (bus.IMEM_REQ) chk("fetch_addr", bus.IMEM_ADDR, exp_fpc);
    if (stall_prev) begin
      chk("stall_valid", 32'(bus.OVALID), 32'd1);
      chk("stall_opc", bus.OPC, held_pc);
      chk("stall_instr", bus.OINSTR, held_ins);
    end
    if (bus.OVALID && bus.OREADY && !redir_val) begin
      chk("stream_opc", bus.OPC, exp_pc);
      chk("stream_instr", bus.OINSTR, mem(exp_pc));
      tx_log.push_back(bus.OPC);
      exp_pc = exp_pc + 32'd4;
      ntx++;
    end
    grant = bus.IMEM_REQ && bus.IMEM_GNT;
    if (grant) begin
      p.a = bus.IMEM_ADDR; p.due = cyc + lat;
      pq.push_back(p);
      exp_fpc = exp_fpc + 32'd4;
    end
    if (rsp) void'(pq.pop_front());
    if (redir_val) begin
      exp_pc  = {redir_pc[31:2], 2'b00};
      exp_fpc = {redir_pc[31:2], 2'b00};
    end
    stall_prev = bus.OVALID && !bus.OREADY && !redir_val;
    held_pc    = bus.OPC;
    held_ins   = bus.OINSTR;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset at a negedge, check outputs drop at once, release next negedge
  task automatic do_reset();
    rstn = 1'b0;
    bus.IMEM_RVALID = 1'b0;
    #1;
    chk("rst_ovalid", 32'(bus.OVALID), 32'd0);
    chk("rst_req", 32'(bus.IMEM_REQ), 32'd0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rstn = 1'b1;
    exp_pc = RST_PC; exp_fpc = RST_PC; stall_prev = 1'b0;
  endtask

  initial begin
    int n0, guard;
    logic [31:0] a0;
    tbl[0] = '{32'h8000_0103, 3, 3, 32'h8000_0100, 32'h8000_0108};
    tbl[1] = '{32'hFFFF_FFF8, 1, 3, 32'hFFFF_FFF8, 32'h0000_0000};
    tbl[2] = '{32'h0000_1236, 2, 4, 32'h0000_1234, 32'h0000_1240};
    tbl[3] = '{32'h8000_0001, 1, 2, 32'h8000_0000, 32'h8000_0004};

    gnt_val = 1'b1; rdy_val = 1'b1; redir_val = 1'b0; redir_pc = '0;
    bus.IMEM_GNT = 1'b0; bus.IMEM_RVALID = 1'b0; bus.IMEM_RDATA = '0;
    bus.REDIRECT = 1'b0; bus.REDIRECT_PC = '0; bus.OREADY = 1'b0;
    stall_prev = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Free run: first OVALID two cycles after release, then 1 instr/cycle
    step(); chk("first_ovalid_c0", 32'(last_ovalid), 32'd0);
            chk("first_req_c0", 32'(last_req), 32'd1);
    step(); chk("first_ovalid_c1", 32'(last_ovalid), 32'd0);
    step(); chk("first_ovalid_c2", 32'(last_ovalid), 32'd1);
    n0 = ntx;
    repeat (20) step();
    chk("throughput", 32'(ntx - n0), 32'd20);

    // Backpressure for 5 cycles: buffer fills, requests stop, head held
    rdy_val = 1'b0;
    repeat (5) step();
    chk("bp_req_low", 32'(last_req), 32'd0);
    chk("bp_valid", 32'(last_ovalid), 32'd1);
    rdy_val = 1'b1;
    repeat (10) step();

    // Grant stall: address held while not granted
    gnt_val = 1'b0;
    step(); a0 = last_addr;
    repeat (3) begin step(); chk("gstall_addr", last_addr, a0); end
    gnt_val = 1'b1;
    repeat (6) step();

    // Redirect table: flush in-flight work, restart at aligned PC
    for (int i = 0; i < 4; i++) begin
      lat = tbl[i].lat;
      repeat (6) step();
      redir_val = 1'b1; redir_pc = tbl[i].rpc;
      step();
      redir_val = 1'b0;
      tx_log.delete();
      step();
      chk("redir_addr", last_addr, tbl[i].first);
      guard = 0;
      while (tx_log.size() < tbl[i].n && guard < 60) begin step(); guard++; end
      if (tx_log.size() < tbl[i].n) chk("redir_timeout", 32'(tx_log.size()), 32'(tbl[i].n));
      else begin
        chk("redir_first_opc", tx_log[0], tbl[i].first);
        chk("redir_last_opc", tx_log[tbl[i].n-1], tbl[i].last);
      end
    end

    // Reset mid-stream with two fetches outstanding
    lat = 3;
    guard = 0;
    while (pq.size() != 2 && guard < 20) begin step(); guard++; end
    chk("rst_setup_outst", 32'(pq.size()), 32'd2);
    do_reset();
    gnt_val = 1'b0;
    repeat (6) begin step(); chk("post_rst_ovalid", 32'(last_ovalid), 32'd0); end
    gnt_val = 1'b1;
    tx_log.delete();
    guard = 0;
    while (tx_log.size() < 1 && guard < 30) begin step(); guard++; end
    if (tx_log.size() < 1) chk("post_rst_timeout", 32'd0, 32'd1);
    else chk("post_rst_first_opc", tx_log[0], RST_PC);

    // Randomized traffic against the stream model
    for (int k = 0; k < 400; k++) begin
      gnt_val   = ($urandom_range(0, 3) != 0);
      rdy_val   = ($urandom_range(0, 3) != 0);
      redir_val = ($urandom_range(0, 24) == 0);
      redir_pc  = $urandom;
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 3);
      step();
    end
    redir_val = 1'b0; gnt_val = 1'b1; rdy_val = 1'b1;
    n0 = ntx;
    repeat (12) step();
    chk("drain_progress", 32'(ntx > n0), 32'd1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
